// File: rtl/bf_weight_loader.sv
// -----------------------------------------------------------------------------
// bf_weight_loader
//
// Holds the per-element phase weights for the beamformer. Weights arrive one
// word at a time into a shadow bank. On commit, the whole shadow bank is copied
// into the active bank in a single edge, aligned to the next frame_tick. The
// phase-shift array downstream therefore never sees a half-updated steering
// vector. If no tick arrives within TIMEOUT cycles, the swap is forced and
// load_err is raised.
//
// Configuration macro: BF_WL_PARITY_EN
//   defined   : wr_data is W_WIDTH+1 bits wide. The MSB makes the whole word even
//               parity. A bad word completes its handshake, is dropped, and sets
//               load_err.
//   undefined : wr_data is W_WIDTH bits wide. No parity check is made.
//
// Ports
//   clock           system clock, rising edge
//   reset           asynchronous, active-low reset
//   wr_valid        write word present
//   wr_ready        loader accepts a write this cycle (IDLE only)
//   wr_addr         [4:3] set (0=cos_1 1=sin_1 2=cos_2 3=sin_2), [2:0] element
//   wr_data         weight word (plus parity MSB with BF_WL_PARITY_EN)
//   commit          request a shadow->active transfer
//   frame_tick      one-cycle pulse marking a legal swap instant
//   commit_pending  high from commit acceptance until the swap completes
//   swap_done       one-cycle pulse in the cycle after the active bank updates
//   load_err        sticky error: timeout swap or parity fault
//   w_cos_1..w_sin_2 registered active bank, one W_WIDTH word per element
// -----------------------------------------------------------------------------
module bf_weight_loader #(
  parameter int W_WIDTH = 5,
  parameter int N_ELEM  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             wr_valid,
  output logic                             wr_ready,
  input  logic [4:0]                       wr_addr,
`ifdef BF_WL_PARITY_EN
  input  logic [W_WIDTH:0]                 wr_data,
`else
  input  logic [W_WIDTH-1:0]               wr_data,
`endif
  input  logic                             commit,
  input  logic                             frame_tick,
  output logic                             commit_pending,
  output logic                             swap_done,
  output logic                             load_err,
  output logic [N_ELEM-1:0][W_WIDTH-1:0]   w_cos_1,
  output logic [N_ELEM-1:0][W_WIDTH-1:0]   w_sin_1,
  output logic [N_ELEM-1:0][W_WIDTH-1:0]   w_cos_2,
  output logic [N_ELEM-1:0][W_WIDTH-1:0]   w_sin_2
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam int EW    = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;

  typedef logic [3:0][N_ELEM-1:0][W_WIDTH-1:0] bank_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_SWAP    = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  bank_t            shadow_q, active_q;
  logic             ready_q, pending_q, done_q, err_q;

  logic             timeout_hit;
  logic             wr_fire;
  logic             word_ok;
  logic             elem_ok;
  logic [W_WIDTH-1:0] word;
  logic [1:0]       wr_set;
  logic [EW-1:0]    elem_idx;

  assign wr_set   = wr_addr[4:3];
  assign elem_idx = wr_addr[EW-1:0];
  // Writes to elements that do not exist still complete the handshake. Their
  // data is dropped.
  assign elem_ok  = (int'(wr_addr[2:0]) < N_ELEM);

`ifdef BF_WL_PARITY_EN
  assign word    = wr_data[W_WIDTH-1:0];
  assign word_ok = ~(^wr_data);
`else
  assign word    = wr_data;
  assign word_ok = 1'b1;
`endif

  assign wr_fire = wr_valid & ready_q;

  // Next-state logic. frame_tick has priority over the timeout, so a tick in the
  // timeout cycle is a clean swap.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d     = state_q;
    timeout_hit = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (commit) state_d = ST_PENDING;
      end
      ST_PENDING: begin
        if (frame_tick) begin
          state_d = ST_SWAP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d     = ST_SWAP;
          timeout_hit = 1'b1;
        end
      end
      ST_SWAP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      // NOTE: both banks are small register arrays. The outputs must read zero
      // out of reset, so the banks are reset too.
      shadow_q  <= '0;
      active_q  <= '0;
      // NOTE: wr_ready is a register. This keeps it low throughout reset even
      // though the state is IDLE.
      ready_q   <= 1'b0;
      pending_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ready_q   <= (state_d == ST_IDLE);
      pending_q <= (state_d != ST_IDLE);
      done_q    <= (state_q == ST_SWAP);
      cnt_q     <= (state_q == ST_PENDING) ? cnt_q + 1'b1 : '0;

      // Every word of the active bank updates on the same edge.
      if (state_q == ST_SWAP) active_q <= shadow_q;

      if (wr_fire && word_ok && elem_ok) shadow_q[wr_set][elem_idx] <= word;

      if (timeout_hit || (wr_fire && !word_ok)) err_q <= 1'b1;
    end
  end

  assign wr_ready       = ready_q;
  assign commit_pending = pending_q;
  assign swap_done      = done_q;
  assign load_err       = err_q;
  assign w_cos_1        = active_q[0];
  assign w_sin_1        = active_q[1];
  assign w_cos_2        = active_q[2];
  assign w_sin_2        = active_q[3];

endmodule

// File: tb/tb_bf_weight_loader.sv
// -----------------------------------------------------------------------------
// tb_bf_weight_loader
//
// Self-checking bench for bf_weight_loader.
//
// The reference model works at the transaction level. It keeps a shadow array
// and an active array. A completed write updates the shadow array. A completed
// swap copies the shadow array into the active array. The model also applies
// the expected swap latency and the sticky error flag.
// -----------------------------------------------------------------------------
module tb_bf_weight_loader;

  localparam int W  = 5;
  localparam int N  = 8;
  localparam int TO = 255;
  localparam int BW = 4 * N * W;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic wr_valid = 1'b0;
  logic commit = 1'b0;
  logic frame_tick = 1'b0;
  logic [4:0] wr_addr = '0;
`ifdef BF_WL_PARITY_EN
  logic [W:0] wr_data = '0;
`else
  logic [W-1:0] wr_data = '0;
`endif
  logic wr_ready, commit_pending, swap_done, load_err;
  logic [N-1:0][W-1:0] w_cos_1, w_sin_1, w_cos_2, w_sin_2;

  always #5 clock = ~clock;

  bf_weight_loader #(.W_WIDTH(W), .N_ELEM(N), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .commit(commit), .frame_tick(frame_tick),
    .commit_pending(commit_pending), .swap_done(swap_done), .load_err(load_err),
    .w_cos_1(w_cos_1), .w_sin_1(w_sin_1), .w_cos_2(w_cos_2), .w_sin_2(w_sin_2)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [W-1:0] sh_m  [4][N];
  logic [W-1:0] act_m [4][N];
  logic         err_m;

  typedef struct {
    logic [1:0]   set;
    logic [2:0]   elem;
    logic [W-1:0] data;
    logic [W-1:0] exp;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [BW-1:0] model_bank();
    logic [BW-1:0] v;
    v = '0;
    for (int s = 0; s < 4; s++)
      for (int e = 0; e < N; e++)
        v[(s*N+e)*W +: W] = act_m[s][e];
    return v;
  endfunction

  function automatic logic [BW-1:0] dut_bank();
    return {w_sin_2, w_cos_2, w_sin_1, w_cos_1};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic reset_model();
    for (int s = 0; s < 4; s++)
      for (int e = 0; e < N; e++) begin
        sh_m[s][e]  = '0;
        act_m[s][e] = '0;
      end
    err_m = 1'b0;
  endtask

  task automatic drive_word(input logic [1:0] s, input logic [2:0] e, input logic [W-1:0] d);
    wr_addr = {s, e};
`ifdef BF_WL_PARITY_EN
    wr_data = {^d, d};
`else
    wr_data = d;
`endif
  endtask

  task automatic do_write(input logic [1:0] s, input logic [2:0] e, input logic [W-1:0] d);
    logic taken;
    taken = 1'b0;
    drive_word(s, e, d);
    wr_valid = 1'b1;
    for (int t = 0; t < 600; t++) begin
      if (wr_ready) begin
        step();
        taken = 1'b1;
        break;
      end
      step();
    end
    wr_valid = 1'b0;
    check("wr_accept", BW'(taken), BW'(1));
    if (taken) sh_m[s][e] = d;
  endtask

  task automatic issue_commit();
    check("commit_ready", BW'(wr_ready), BW'(1));
    commit = 1'b1;
    step();
    commit = 1'b0;
    check("commit_pending_set", BW'(commit_pending), BW'(1));
  endtask

  // n = cycles from commit acceptance to the tick edge. n = 0 means no tick
  // arrives, so the swap is forced by the timeout.
  task automatic wait_swap(input int n);
    int edges;
    edges = (n == 0) ? TO : n;
    for (int i = 1; i <= edges; i++) begin
      check("pend_ready_low", BW'(wr_ready), BW'(0));
      check("pend_flag", BW'(commit_pending), BW'(1));
      check("pend_bank_hold", dut_bank(), model_bank());
      commit     = (i < edges) ? 1'($urandom_range(0, 1)) : 1'b0;
      frame_tick = (n != 0) && (i == edges);
      step();
    end
    commit     = 1'b0;
    frame_tick = 1'b0;
    check("swap_bank_hold", dut_bank(), model_bank());
    check("swap_done_early", BW'(swap_done), BW'(0));
    step();
    if (n == 0) err_m = 1'b1;
    for (int s = 0; s < 4; s++)
      for (int e = 0; e < N; e++)
        act_m[s][e] = sh_m[s][e];
    check("swap_bank_new", dut_bank(), model_bank());
    check("swap_done_pulse", BW'(swap_done), BW'(1));
    check("pending_clear", BW'(commit_pending), BW'(0));
    check("load_err", BW'(load_err), BW'(err_m));
    step();
    check("swap_done_drop", BW'(swap_done), BW'(0));
    check("no_queued_commit", BW'(commit_pending), BW'(0));
  endtask

  task automatic commit_and_swap(input int n);
    issue_commit();
    wait_swap(n);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  initial begin
    logic [1:0]   rs;
    logic [2:0]   re;
    logic [W-1:0] rd;
    int           nw, nd;

    reset_model();

    // Reset held three cycles, then released.
    step(); step(); step();
    check("rst_bank_zero", dut_bank(), '0);
    check("rst_ready_low", BW'(wr_ready), BW'(0));
    check("rst_pending", BW'(commit_pending), BW'(0));
    check("rst_swap_done", BW'(swap_done), BW'(0));
    check("rst_load_err", BW'(load_err), BW'(0));
    reset = 1'b1;
    step();
    check("rel_ready_high", BW'(wr_ready), BW'(1));

    // Single word, tick four cycles after commit.
    do_write(2'd0, 3'd3, 5'h0B);
    commit_and_swap(4);
    check("cos1_3_value", BW'(w_cos_1[3]), BW'(5'h0B));

    // Table of writes with the expected final value of each address.
    tbl[0] = '{2'd0, 3'd0, 5'h01, 5'h1F};
    tbl[1] = '{2'd0, 3'd0, 5'h1F, 5'h1F};
    tbl[2] = '{2'd1, 3'd7, 5'h10, 5'h10};
    tbl[3] = '{2'd2, 3'd4, 5'h0F, 5'h0F};
    tbl[4] = '{2'd3, 3'd2, 5'h15, 5'h15};
    tbl[5] = '{2'd0, 3'd3, 5'h00, 5'h00};
    tbl[6] = '{2'd3, 3'd7, 5'h1E, 5'h1E};
    tbl[7] = '{2'd2, 3'd1, 5'h11, 5'h11};
    for (int i = 0; i < 8; i++) do_write(tbl[i].set, tbl[i].elem, tbl[i].data);
    commit_and_swap(3);
    for (int i = 0; i < 8; i++)
      check($sformatf("tbl_word_%0d", i),
            BW'(dut_bank()[(int'(tbl[i].set)*N + int'(tbl[i].elem))*W +: W]),
            BW'(tbl[i].exp));

    // All 32 words, then a write held through PENDING.
    for (int s = 0; s < 4; s++)
      for (int e = 0; e < N; e++)
        do_write(2'(s), 3'(e), 5'($urandom_range(0, 31)));
    issue_commit();
    rd = ~sh_m[1][2];
    drive_word(2'd1, 3'd2, rd);
    wr_valid = 1'b1;
    // The held write is accepted on the last edge of wait_swap.
    wait_swap(6);
    wr_valid = 1'b0;
    sh_m[1][2] = rd;
    commit_and_swap(1);

    // Write and commit in the same cycle, with the tick in the timeout cycle.
    check("wc_ready", BW'(wr_ready), BW'(1));
    drive_word(2'd3, 3'd5, 5'h09);
    wr_valid = 1'b1;
    commit   = 1'b1;
    step();
    wr_valid = 1'b0;
    commit   = 1'b0;
    sh_m[3][5] = 5'h09;
    check("wc_pending", BW'(commit_pending), BW'(1));
    wait_swap(TO);
    check("wc_no_err", BW'(load_err), BW'(0));

    // No tick at all, so the swap is forced by the timeout.
    do_write(2'd2, 3'd6, 5'h1A);
    commit_and_swap(0);
    check("to_err_set", BW'(load_err), BW'(1));

`ifdef BF_WL_PARITY_EN
    // Parity: a good word is stored, a bad word is dropped.
    check("par_ready", BW'(wr_ready), BW'(1));
    wr_addr  = 5'd0;
    wr_data  = 6'b1_00001;
    wr_valid = 1'b1;
    step();
    sh_m[0][0] = 5'h01;
    wr_addr  = 5'd1;
    wr_data  = 6'b0_00001;
    step();
    wr_valid = 1'b0;
    err_m    = 1'b1;
    check("par_err", BW'(load_err), BW'(1));
    commit_and_swap(2);
`endif

    // Randomised traffic checked against the model.
    for (int iter = 0; iter < 25; iter++) begin
      nw = $urandom_range(0, 8);
      for (int k = 0; k < nw; k++) begin
        if ($urandom_range(0, 3) == 0) begin
          frame_tick = 1'b1;
          step();
          frame_tick = 1'b0;
          check("idle_tick_ignored", dut_bank(), model_bank());
          check("idle_no_pending", BW'(commit_pending), BW'(0));
        end
        rs = 2'($urandom_range(0, 3));
        re = 3'($urandom_range(0, N - 1));
        rd = 5'($urandom_range(0, 31));
        do_write(rs, re, rd);
      end
      nd = (iter % 12 == 5) ? 0 : $urandom_range(1, 20);
      commit_and_swap(nd);
    end
    check("err_sticky", BW'(load_err), BW'(1));

    // Reset in the middle of PENDING: both banks clear, the commit is lost.
    issue_commit();
    step(); step(); step();
    reset = 1'b0;
    #1;
    check("midrst_bank", dut_bank(), '0);
    check("midrst_pending", BW'(commit_pending), BW'(0));
    check("midrst_err", BW'(load_err), BW'(0));
    check("midrst_ready", BW'(wr_ready), BW'(0));
    step(); step();
    reset = 1'b1;
    step();
    check("midrst_ready_rel", BW'(wr_ready), BW'(1));
    reset_model();
    commit_and_swap(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
